uart_tx_flow: RTL

Parametrised UART transmitter with integrated baud generator and RTS/CTS-style flow control. It replaces the fixed 9600-baud, 8-bit transmitter and its separate baud-clock divider. It accepts bytes over a valid/ready handshake and serialises them LSB-first onto `txd`. A frame starts only while the remote side asserts CTS. It sits between on-chip byte producers and the PMOD pin driving the TTL-USB adapter.

---
 rtl/uart_tx_flow.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_flow.sv
// rtl/uart_tx_flow.sv - UART transmitter with baud generator and CTS flow control; optional parity via UART_TX_FLOW_PARITY_EN
module uart_tx_flow #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 hwclk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 cts_n,
    output logic                 txd,
    output logic                 busy
);

    // Clock cycles per bit, rounded to nearest.
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_TX_FLOW_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif
    localparam logic [2:0] S_STOP   = 3'd5;

    // Elaboration-time guards on the legal parameter ranges.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_flow: CLK_HZ/BAUD must give at least 2 cycles per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_flow: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_flow: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_flow: PARITY_ODD must be 0 or 1");
    end

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 cts_meta_q, cts_meta_d;
    logic                 cts_sync_q, cts_sync_d;
    logic                 txd_q, txd_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;
`ifdef UART_TX_FLOW_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Last cycle of the current bit period.
    assign bit_end = (cnt_q == CNT_LAST);

    // Two-flop synchroniser for the asynchronous CTS input.
    always_comb begin
        cts_meta_d = cts_n;
        cts_sync_d = cts_meta_q;
    end

    // Frame sequencer: next state, baud/bit/stop counters and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
`ifdef UART_TX_FLOW_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid && tx_ready_q) begin
                    shift_d = tx_data;
`ifdef UART_TX_FLOW_PARITY_EN
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter held at zero so the start bit is always full width.
                cnt_d = '0;
                if (!cts_sync_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        stop_d  = 1'b0;
`ifdef UART_TX_FLOW_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_FLOW_PARITY_EN
            S_PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered.
    always_comb begin
        txd_d      = 1'b1;
        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_FLOW_PARITY_EN
            S_PARITY: txd_d = par_q;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // State and output registers; reset idles the line high immediately.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            cts_meta_q <= cts_meta_d;
            cts_sync_q <= cts_sync_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_TX_FLOW_PARITY_EN
    // Parity bit computed at acceptance.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule
